// File: rtl/sha3_unpad_pkg.sv
// Shared definitions for the SHA-3 unpadder: FSM encoding, pad marker byte,
// default rate and a byte-mask helper.
// Build option: UNPAD_FIPS_COMPAT_EN selects the FIPS 202 domain marker (0x06)
// instead of the original Keccak marker (0x01).
package sha3_unpad_pkg;

    localparam int unsigned DEFAULT_RATE_WORDS = 18;

    // Enough for 4 * 32 = 128 bytes per block.
    localparam int unsigned LEN_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

`ifdef UNPAD_FIPS_COMPAT_EN
    localparam logic [7:0] MARKER = 8'h06;
`else
    localparam logic [7:0] MARKER = 8'h01;
`endif

    // Keep the first nbytes bytes (byte 0 sits in [31:24]), zero the rest.
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(nbytes)) m[31-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/unpad_scan1.sv
// Combinational per-word padding finder: locates the highest-index nonzero
// byte of one buffered word and checks it against the pad marker.
module unpad_scan1
    import sha3_unpad_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic        is_last_word_i,
    output logic        found_o,
    output logic [1:0]  idx_o,
    output logic        marker_ok_o
);

    logic [31:0] word_m;
    logic [7:0]  sel_byte;

    // Find the last nonzero byte; the trailing pad bit is masked on the block's final word.
    always_comb begin
        word_m = word_i;
        if (is_last_word_i) word_m[7] = 1'b0;
        found_o  = 1'b0;
        idx_o    = 2'd0;
        sel_byte = 8'h00;
        // Ascending scan so the highest nonzero index wins.
        for (int b = 0; b < 4; b++) begin
            if (word_m[31-8*b -: 8] != 8'h00) begin
                found_o  = 1'b1;
                idx_o    = 2'(b);
                sel_byte = word_m[31-8*b -: 8];
            end
        end
        marker_ok_o = found_o && (sel_byte == MARKER);
    end

endmodule

// File: rtl/unpadder.sv
// Receive-side SHA-3 unpadder: buffers one rate block, strips pad10*1 from the
// final block by scanning backward one word per cycle, and replays the message.
// Build option: UNPAD_FIPS_COMPAT_EN (marker byte selection, see sha3_unpad_pkg).
module unpadder
    import sha3_unpad_pkg::*;
#(
    parameter int unsigned RATE_WORDS = DEFAULT_RATE_WORDS
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] in_i,
    input  logic        in_valid_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic [31:0] out_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic [2:0]  out_bytes_o,
    output logic        pad_err_o
);

    localparam int unsigned WCW = $clog2(RATE_WORDS);
    localparam logic [WCW-1:0]   LAST_W   = WCW'(RATE_WORDS - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(4 * RATE_WORDS);

    state_t            state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [WCW-1:0]    w_q, w_d;
    logic [WCW-1:0]    rcnt_q, rcnt_d;
    logic [LEN_W-1:0]  msg_len_q, msg_len_d;
    logic              final_q, final_d;
    logic              pad_err_q, pad_err_d;
    logic [31:0]       mem_q [RATE_WORDS];

    logic              in_hs;
    logic [31:0]       scan_word;
    logic              scan_is_last;
    logic              scan_found;
    logic [1:0]        scan_idx;
    logic              scan_marker_ok;
    logic              scan_err;
    logic [LEN_W-1:0]  rem;
    logic [2:0]        cur_bytes;
    logic              drain_last;

    assign in_ready_o  = (state_q == ST_FILL);
    assign out_valid_o = (state_q == ST_DRAIN);
    assign in_hs       = in_valid_i && in_ready_o;
    assign pad_err_o   = pad_err_q;

    assign scan_word    = mem_q[w_q];
    assign scan_is_last = (w_q == LAST_W);

    unpad_scan1 u_scan1 (
        .word_i         (scan_word),
        .is_last_word_i (scan_is_last),
        .found_o        (scan_found),
        .idx_o          (scan_idx),
        .marker_ok_o    (scan_marker_ok)
    );

    // Missing trailing 1, wrong marker, or no marker anywhere in the block.
    assign scan_err = (scan_is_last && !scan_word[7]) ||
                      (scan_found && !scan_marker_ok) ||
                      (!scan_found && (w_q == '0));

    // Output word shaping: bytes left in the message decide mask and last flag.
    always_comb begin
        rem        = msg_len_q - LEN_W'({rcnt_q, 2'b00});
        cur_bytes  = (rem >= LEN_W'(4)) ? 3'd4 : rem[2:0];
        drain_last = (rem <= LEN_W'(4));
        if (out_valid_o) begin
            out_o       = mem_q[rcnt_q] & byte_mask(cur_bytes);
            out_bytes_o = cur_bytes;
            out_last_o  = final_q && drain_last;
        end else begin
            out_o       = 32'h0;
            out_bytes_o = 3'd0;
            out_last_o  = 1'b0;
        end
    end

    // FILL / SCAN / DRAIN next-state logic.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        w_d       = w_q;
        rcnt_d    = rcnt_q;
        msg_len_d = msg_len_q;
        final_d   = final_q;
        pad_err_d = pad_err_q;
        case (state_q)
            ST_FILL: begin
                if (in_hs) begin
                    if (wcnt_q == LAST_W) begin
                        wcnt_d = '0;
                        rcnt_d = '0;
                        if (in_last_i) begin
                            state_d = ST_SCAN;
                            final_d = 1'b1;
                            w_d     = LAST_W;
                        end else begin
                            state_d   = ST_DRAIN;
                            final_d   = 1'b0;
                            msg_len_d = FULL_LEN;
                        end
                    end else if (in_last_i) begin
                        // Short final block: drop it and resynchronise.
                        pad_err_d = 1'b1;
                        wcnt_d    = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_err) begin
                    pad_err_d = 1'b1;
                    state_d   = ST_FILL;
                end else if (scan_found) begin
                    msg_len_d = LEN_W'({w_q, 2'b00}) + LEN_W'(scan_idx);
                    rcnt_d    = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    w_d = w_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (drain_last) begin
                        rcnt_d  = '0;
                        wcnt_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_FILL;
            wcnt_q    <= '0;
            w_q       <= '0;
            rcnt_q    <= '0;
            msg_len_q <= '0;
            final_q   <= 1'b0;
            pad_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            w_q       <= w_d;
            rcnt_q    <= rcnt_d;
            msg_len_q <= msg_len_d;
            final_q   <= final_d;
            pad_err_q <= pad_err_d;
        end
    end

    // Block buffer, written on each accepted input word; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (in_hs) mem_q[wcnt_q] <= in_i;
    end

endmodule

// File: tb/tb_unpadder.sv
// Directed self-checking bench for unpadder (default rate of 18 words).
module tb_unpadder;
    import sha3_unpad_pkg::*;

    localparam int R  = 18;
    localparam int BB = 4 * R;

    logic        clk;
    logic        reset_i;
    logic [31:0] in_i;
    logic        in_valid_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic [31:0] out_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic [2:0]  out_bytes_o;
    logic        pad_err_o;

    unpadder #(.RATE_WORDS(R)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_i        (in_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .out_bytes_o (out_bytes_o),
        .pad_err_o   (pad_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mb [0:255];
    logic [31:0] blk [R];
    logic [31:0] q_data [$];
    logic [2:0]  q_bytes [$];
    logic        q_last [$];
    bit          tog_en = 1'b0;
    int          lat_first, lat_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Consumer ready: constant 1, or toggling every cycle.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = tog_en ? ~out_ready_i : 1'b1;
        end
    end

    // Output monitor: record handshakes, check stability while stalled.
    initial begin
        logic        hold_v;
        logic [31:0] hold_d;
        logic [2:0]  hold_b;
        logic        hold_l;
        hold_v = 1'b0;
        hold_d = '0;
        hold_b = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    chk("hold_stable", {28'h0, out_valid_o, out_last_o, out_bytes_o, out_o},
                        {28'h0, 1'b1, hold_l, hold_b, hold_d});
                if (out_valid_o && out_ready_i) begin
                    q_data.push_back(out_o);
                    q_bytes.push_back(out_bytes_o);
                    q_last.push_back(out_last_o);
                end
                hold_v = out_valid_o && !out_ready_i;
                hold_d = out_o;
                hold_b = out_bytes_o;
                hold_l = out_last_o;
            end
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_bytes.delete();
        q_last.delete();
    endtask

    function automatic logic [7:0] pad_byte(input int i, input int len, input int nblk);
        logic [7:0] b;
        if (i < len) b = mb[i];
        else if (i == len) b = MARKER;
        else b = 8'h00;
        if (i == nblk * BB - 1) b = b | 8'h80;
        return b;
    endfunction

    task automatic send_word(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        in_i       = w;
        in_valid_i = 1'b1;
        in_last_i  = l;
        @(negedge clk);
        while (!in_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {63'h0, in_ready_o}, 64'h1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic measure_lat(output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_o && n < 200);
        lat = n;
    endtask

    task automatic send_msg(input int len);
        int nblk;
        nblk = (len + BB) / BB;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < R; w++) begin
                logic [31:0] wd;
                for (int j = 0; j < 4; j++) wd[31-8*j -: 8] = pad_byte(b*BB + w*4 + j, len, nblk);
                send_word(wd, (b == nblk - 1) && (w == R - 1));
            end
            if (b == 0) measure_lat(lat_first);
            if (b == nblk - 1) begin
                if (b == 0) lat_last = lat_first;
                else measure_lat(lat_last);
            end
        end
    endtask

    task automatic send_blk();
        for (int w = 0; w < R; w++) send_word(blk[w], w == R - 1);
    endtask

    // Compare collected output against the message bytes and the expected latencies.
    task automatic check_msg(input string tag, input int len);
        int nblk, nfull, r, nfin, nexp, n, sz;
        nblk  = (len + BB) / BB;
        nfull = (nblk - 1) * R;
        r     = len - BB * (nblk - 1);
        nfin  = (r == 0) ? 1 : (r + 3) / 4;
        nexp  = nfull + nfin;
        n = 0;
        while (q_data.size() < nexp && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        sz = q_data.size();
        chk({tag, "_count"}, 64'(sz), 64'(nexp));
        for (int i = 0; i < nexp && i < sz; i++) begin
            logic [31:0] ed;
            logic [2:0]  eb;
            logic        el;
            ed = '0;
            if (i < nfull) begin
                for (int j = 0; j < 4; j++) ed[31-8*j -: 8] = mb[4*i + j];
                eb = 3'd4;
                el = 1'b0;
            end else begin
                int fi, nb;
                fi = i - nfull;
                nb = r - 4 * fi;
                if (nb > 4) nb = 4;
                eb = 3'(nb);
                for (int j = 0; j < nb; j++) ed[31-8*j -: 8] = mb[(nblk-1)*BB + 4*fi + j];
                el = (fi == nfin - 1);
            end
            chk($sformatf("%s_w%0d", tag, i), {28'h0, q_last[i], q_bytes[i], q_data[i]},
                {28'h0, el, eb, ed});
        end
        if (nblk > 1) chk({tag, "_lat_first"}, 64'(lat_first), 64'd1);
        chk({tag, "_lat_last"}, 64'(lat_last), 64'(1 + R - r / 4));
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mb(input int len, input int seed);
        for (int i = 0; i < len; i++) mb[i] = 8'(i * 29 + seed);
    endtask

    task automatic set_msg5();
        mb[0] = 8'h11; mb[1] = 8'h22; mb[2] = 8'h33; mb[3] = 8'h44; mb[4] = 8'h55;
    endtask

    initial begin
        int n;
        reset_i    = 1'b1;
        in_i       = '0;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        #1;
        chk("rst_in_ready", {63'h0, in_ready_o}, 64'h1);
        chk("rst_out", {28'h0, out_valid_o, out_last_o, out_bytes_o, out_o}, 64'h0);
        chk("rst_pad_err", {63'h0, pad_err_o}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        // 5-byte message 11 22 33 44 55.
        set_msg5();
        send_msg(5);
        check_msg("msg5", 5);
        if (q_data.size() == 2) begin
            chk("msg5_lit0", {28'h0, q_last[0], q_bytes[0], q_data[0]}, {28'h0, 1'b0, 3'd4, 32'h11223344});
            chk("msg5_lit1", {28'h0, q_last[1], q_bytes[1], q_data[1]}, {28'h0, 1'b1, 3'd1, 32'h55000000});
        end
        clear_q();

        // 71 bytes: marker shares the last byte with the trailing pad bit.
        fill_mb(71, 3);
        send_msg(71);
        check_msg("msg71", 71);
        clear_q();

        // 72 bytes: full data block followed by an all-padding block.
        fill_mb(72, 7);
        send_msg(72);
        check_msg("msg72", 72);
        clear_q();
        chk("pad_err_clean", {63'h0, pad_err_o}, 64'h0);

        // Final word without the trailing 0x80.
        set_msg5();
        for (int w = 0; w < R; w++) blk[w] = 32'h0;
        blk[0] = 32'h11223344;
        blk[1] = {8'h55, MARKER, 16'h0000};
        send_blk();
        repeat (30) @(negedge clk);
        chk("no80_pad_err", {63'h0, pad_err_o}, 64'h1);
        chk("no80_no_out", 64'(q_data.size()), 64'd0);
        @(posedge clk);
        #1;

        send_msg(5);
        check_msg("after_no80", 5);
        clear_q();

        // Wrong marker byte.
        blk[1]     = 32'h55070000;
        blk[R - 1] = 32'h00000080;
        send_blk();
        repeat (30) @(negedge clk);
        chk("badmk_no_out", 64'(q_data.size()), 64'd0);
        chk("badmk_in_ready", {63'h0, in_ready_o}, 64'h1);
        @(posedge clk);
        #1;

        // Consumer toggling ready every cycle.
        tog_en = 1'b1;
        fill_mb(71, 11);
        send_msg(71);
        check_msg("toggle71", 71);
        clear_q();
        tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a drain.
        fill_mb(71, 13);
        send_msg(71);
        n = 0;
        while (q_data.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("mid_drain_reached", 64'(q_data.size() >= 3), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_out", {28'h0, out_valid_o, out_last_o, out_bytes_o, out_o}, 64'h0);
        chk("mid_rst_pad_err", {63'h0, pad_err_o}, 64'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", {63'h0, in_ready_o}, 64'h1);
        @(negedge clk);
        reset_i = 1'b0;
        clear_q();
        @(posedge clk);
        #1;

        // in_last on a word that does not close a block.
        send_word(32'hAABBCCDD, 1'b0);
        send_word(32'h01020304, 1'b0);
        send_word(32'h05060708, 1'b1);
        repeat (5) @(negedge clk);
        chk("short_pad_err", {63'h0, pad_err_o}, 64'h1);
        chk("short_no_out", 64'(q_data.size()), 64'd0);
        @(posedge clk);
        #1;

        fill_mb(9, 17);
        send_msg(9);
        check_msg("msg9", 9);
        clear_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unpadder.md
# unpadder

Receive-side counterpart of the SHA-3 padder in the low-throughput core. Accepts a 32-bit word stream of padded rate blocks, buffers one block, and on the final block scans backward to locate and strip the pad10*1 padding. Emits the original message as 32-bit words with a byte count on the last word. Used for loopback verification of the padder and for cores that receive pre-padded blocks.

## Interface
- RATE_WORDS, 18, words per rate block (576-bit rate); legal range 2..32.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in  in  32  padded word; byte 0 (first in message order) is in[31:24].
- in_valid  in  1  in carries a word.
- in_last  in  1  with in_valid: final word of final block.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out  out  32  message word, same byte order; unused bytes are zero.
- out_valid  out  1  out holds a word.
- out_ready  in  1  consumer takes word when out_valid && out_ready.
- out_last  out  1  final word of message.
- out_bytes  out  3  valid bytes in out, 4 on all non-last words, 0..4 on last.
- pad_err  out  1  sticky: malformed padding or misplaced in_last.

## Operation
- States: FILL, SCAN, DRAIN.
- FILL: in_ready=1; words written to buffer[wcnt], wcnt++. Accepting word RATE_WORDS-1: next state SCAN if in_last, else DRAIN with msg_len=4*RATE_WORDS. in_last on any other word: pad_err set, block discarded, wcnt=0, stay FILL.
- SCAN (in_ready=0): pointer w starts at RATE_WORDS-1. Entry check: buffer[RATE_WORDS-1][7] must be 1, else error. Last byte is examined with bit 7 cleared (0x80→0x00, 0x86→0x06). Per cycle, one word: locate highest-index nonzero byte b. None: w--. Found: byte must equal MARKER, else error; msg_len=4*w+b, go DRAIN. w=0 with no nonzero byte: error.
- Error in SCAN: pad_err set, block discarded, return FILL.
- DRAIN (in_ready=0): rcnt from 0; out=buffer[rcnt] with bytes ≥ remaining length zeroed. Non-final block: RATE_WORDS words, out_bytes=4, out_last=0. Final block, msg_len>0: ceil(msg_len/4) words, last has out_last=1, out_bytes=msg_len-4*(n-1). Final block, msg_len=0 (message ended on block boundary, or empty message): one terminator word out=0, out_bytes=0, out_last=1. After last handshake: wcnt=0, FILL.
- Multiple messages back-to-back are supported; pad_err does not block further traffic.

## Timing
- Reset values: state=FILL, wcnt=rcnt=0, in_ready=1, out_valid=0, out=0, out_last=0, out_bytes=0, pad_err=0. Buffer not reset.
- Non-final block: first out_valid one cycle after last input handshake.
- Final block: SCAN takes RATE_WORDS-w cycles (1..RATE_WORDS), then DRAIN next cycle.
- out, out_last, out_bytes stable while out_valid && !out_ready; out_valid never drops without handshake.
- Back-to-back output: one word per cycle when out_ready=1.
- in_valid ignored outside FILL; no input-output overlap (single buffer).
- Reset mid-block or mid-drain: all in-flight data dropped, outputs to reset values immediately.

## Configuration
- UNPAD_FIPS_COMPAT_EN defined: MARKER=0x06 (FIPS 202 SHA-3 domain bits).
- Undefined: MARKER=0x01 (original Keccak). Trailing 0x80 rule unchanged in both.

## Structure
- Package sha3_unpad_pkg: state enum, MARKER constant (macro-selected), default RATE_WORDS, byte-mask helper.
- Sub-module unpad_scan1: combinational per-word finder: in 32-bit word, is_last_word flag → found, byte index, marker_ok. Instantiated once in SCAN datapath.

## Test plan
- Message 0x11223344_55 (5 bytes), FIPS: block word0=0x11223344, word1=0x55060000, zeros, word17=0x00000080 → out 0x11223344 (4), 0x55000000 (out_bytes=1, out_last).
- Message of 71 bytes: last byte of block 0x86 → 18 words, last out_bytes=3, out_last=1; SCAN lasts 1 cycle.
- Message of 72 bytes: block1 full data, block2 = 0x06000000…0x00000080 → 18 words bytes=4, then terminator out=0, out_bytes=0, out_last.
- Final word 0x00000000 (no 0x80) or wrong marker 0x07 → pad_err=1, no output, next valid message decodes correctly.
- out_ready toggling 1/0 each cycle during DRAIN → each word held until accepted, no loss/duplication.
- Assert reset in DRAIN after 3 words → out_valid=0, in_ready=1 next edge; fresh message decodes normally.
